// File: rtl/weight_rd_sched_pkg.sv
// Shared constants and FSM encoding for the weight-buffer read scheduler.
package weight_rd_sched_pkg;

  localparam int WT_ADDR_W  = 11;
  localparam int WT_NUM_COL = 8;
  localparam int WT_PASS_W  = 8;
  localparam int LAYER_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/weight_rd_sched_if.sv
// Job handshake plus weight-buffer read bus between layer controller, scheduler and buffer.
interface weight_rd_sched_if
  import weight_rd_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = WT_ADDR_W,
  parameter int NUM_COL    = WT_NUM_COL,
  parameter int PASS_WIDTH = WT_PASS_W
) ();

  logic                          start;
  logic [LAYER_W-1:0]            cfg_layer;
  logic [ADDR_WIDTH-1:0]         cfg_base;
  logic [ADDR_WIDTH-1:0]         cfg_len;
  logic [PASS_WIDTH-1:0]         cfg_pass;
  logic                          stall;
  logic                          busy;
  logic                          done;
  logic [LAYER_W-1:0]            layer2weight_cnt;
  logic [NUM_COL*ADDR_WIDTH-1:0] wt_addr;
  logic [NUM_COL-1:0]            wt_vld;

  modport master (
    output start, cfg_layer, cfg_base, cfg_len, cfg_pass, stall,
    input  busy, done, layer2weight_cnt, wt_addr, wt_vld
  );

  modport slave (
    input  start, cfg_layer, cfg_base, cfg_len, cfg_pass, stall,
    output busy, done, layer2weight_cnt, wt_addr, wt_vld
  );

endinterface

// File: rtl/weight_rd_stagger.sv
// DEPTH-stage addr+vld delay line with hold; output stage i lags the input by i+1 enabled cycles.
module weight_rd_stagger #(
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic                        in_vld,
  output logic [DEPTH*ADDR_WIDTH-1:0] out_addr,
  output logic [DEPTH-1:0]            out_vld
);

  logic [ADDR_WIDTH-1:0] addr_p [DEPTH];
  logic [DEPTH-1:0]      vld_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) addr_p[i] <= '0;
      vld_p <= '0;
    end else if (en) begin
      addr_p[0] <= in_addr;
      vld_p[0]  <= in_vld;
      for (int i = 1; i < DEPTH; i++) begin
        addr_p[i] <= addr_p[i-1];
        vld_p[i]  <= vld_p[i-1];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign out_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = addr_p[g];
  end
  assign out_vld = vld_p;

endmodule

// File: rtl/weight_rd_sched.sv
// Weight-buffer read scheduler: issues len*pass column-0 reads and staggers them across NUM_COL columns.
module weight_rd_sched
  import weight_rd_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = WT_ADDR_W,
  parameter int NUM_COL    = WT_NUM_COL,
  parameter int PASS_WIDTH = WT_PASS_W
) (
  input  logic         clk_cal,
  input  logic         rst_cal,
  weight_rd_sched_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_COL);

  sched_state_t state, state_nxt;

  logic [LAYER_W-1:0]    layer_q;
  logic [ADDR_WIDTH-1:0] base_q, len_q, idx_q, addr0_q;
  logic [PASS_WIDTH-1:0] pass_q, pidx_q;
  logic [CNT_W-1:0]      drain_q;
  logic                  vld0_q, busy_q, done_q;

  logic accept, hold, step, job_empty, idx_last, pass_last, drain_last;

  logic [(NUM_COL-1)*ADDR_WIDTH-1:0] chain_addr;
  logic [NUM_COL-2:0]                chain_vld;

  always_ff @(posedge clk_cal) begin
    if (rst_cal) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = job_empty ? S_DONE : S_RUN;
      S_RUN:   if (step && idx_last && pass_last) state_nxt = S_DRAIN;
      S_DRAIN: if (step && drain_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stall only freezes the read pipeline; outside RUN/DRAIN it is ignored.
  always_comb begin
    accept     = (state == S_IDLE) && bus.start;
    hold       = bus.stall && ((state == S_RUN) || (state == S_DRAIN));
    step       = !hold;
    job_empty  = (len_q == '0) || (pass_q == '0);
    idx_last   = (idx_q == len_q - ADDR_WIDTH'(1));
    pass_last  = (pidx_q == pass_q - PASS_WIDTH'(1));
    drain_last = (drain_q == CNT_W'(NUM_COL-2));
  end

  // Column-0 issue stage: counters track the element currently on the output.
  always_ff @(posedge clk_cal) begin
    if (rst_cal) begin
      layer_q <= '0;
      base_q  <= '0;
      len_q   <= '0;
      pass_q  <= '0;
      idx_q   <= '0;
      pidx_q  <= '0;
      addr0_q <= '0;
      vld0_q  <= 1'b0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state_nxt != S_IDLE);
      done_q <= (state_nxt == S_DONE);
      if (accept) begin
        layer_q <= bus.cfg_layer;
        base_q  <= bus.cfg_base;
        len_q   <= bus.cfg_len;
        pass_q  <= bus.cfg_pass;
      end
      if ((state == S_LOAD) && !job_empty) begin
        addr0_q <= base_q;
        vld0_q  <= 1'b1;
        idx_q   <= '0;
        pidx_q  <= '0;
      end else if ((state == S_RUN) && step) begin
        if (idx_last && pass_last) begin
          vld0_q <= 1'b0;
        end else if (idx_last) begin
          idx_q   <= '0;
          pidx_q  <= pidx_q + PASS_WIDTH'(1);
          addr0_q <= base_q;
        end else begin
          idx_q   <= idx_q + ADDR_WIDTH'(1);
          addr0_q <= addr0_q + ADDR_WIDTH'(1);
        end
      end
      if (state != S_DRAIN)  drain_q <= '0;
      else if (step)         drain_q <= drain_q + CNT_W'(1);
    end
  end

  // Columns 1..NUM_COL-1: systolic stagger behind column 0.
  weight_rd_stagger #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (NUM_COL-1)
  ) u_stagger (
    .clk      (clk_cal),
    .rst      (rst_cal),
    .en       (step),
    .in_addr  (addr0_q),
    .in_vld   (vld0_q),
    .out_addr (chain_addr),
    .out_vld  (chain_vld)
  );

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.layer2weight_cnt = layer_q;
  assign bus.wt_addr          = {chain_addr, addr0_q};
  assign bus.wt_vld           = hold ? '0 : {chain_vld, vld0_q};

endmodule
